// File: rtl/dm_block_mover.sv
// Block-transfer initiator for the data memory: COPY a run of words or FILL a region with a constant.
// Owns the memory port while busy; all outputs are registered and cleared by reset.
module dm_block_mover #(
  parameter int unsigned WIDTH     = 21,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] src_addr,
  input  logic [ADDR_BITS-1:0] dst_addr,
  input  logic [ADDR_BITS:0]   len,
  input  logic [WIDTH-1:0]     fill_value,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam logic [ADDR_BITS:0] Depth = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e               state_q;
  logic                 fill_mode_q;
  logic [ADDR_BITS-1:0] src_ptr_q;
  logic [ADDR_BITS-1:0] dst_ptr_q;
  logic [ADDR_BITS:0]   count_q;
  logic [WIDTH-1:0]     fill_q;
  logic [ADDR_BITS:0]   len_clamped;

  assign len_clamped = (len > Depth) ? Depth : len;

  // mem_wdata doubles as the read-data holding register between READ and WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fill_mode_q <= 1'b0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      count_q     <= '0;
      fill_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            fill_mode_q <= mode;
            src_ptr_q   <= src_addr;
            dst_ptr_q   <= dst_addr;
            fill_q      <= fill_value;
            count_q     <= len_clamped;
            if (len_clamped == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else if (!mode) begin
              state_q  <= StRead;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end else begin
              state_q   <= StWrite;
              busy      <= 1'b1;
              mem_addr  <= dst_addr;
              mem_wdata <= fill_value;
              mem_we    <= 1'b1;
            end
          end
        end
        StRead: begin
          state_q   <= StWrite;
          mem_addr  <= dst_ptr_q;
          mem_wdata <= mem_rdata;
          mem_we    <= 1'b1;
        end
        StWrite: begin
          dst_ptr_q <= dst_ptr_q + 1'b1;
          count_q   <= count_q - 1'b1;
          if (!fill_mode_q) src_ptr_q <= src_ptr_q + 1'b1;
          if (count_q == 1) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else if (!fill_mode_q) begin
            state_q   <= StRead;
            mem_we    <= 1'b0;
            mem_addr  <= src_ptr_q + 1'b1;
            mem_wdata <= '0;
          end else begin
            state_q   <= StWrite;
            mem_addr  <= dst_ptr_q + 1'b1;
            mem_wdata <= fill_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_block_mover.sv
// Directed bench for dm_block_mover with a behavioural 64x21 memory attached to its port.
module tb_dm_block_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [5:0]  src_addr;
  logic [5:0]  dst_addr;
  logic [6:0]  len;
  logic [20:0] fill_value;
  logic        busy;
  logic        done;
  logic [5:0]  mem_addr;
  logic [20:0] mem_wdata;
  logic        mem_we;
  logic [20:0] mem_rdata;

  logic [20:0] mem [64];
  logic        pl_bg = 1'b0;
  logic        pl_we = 1'b0;
  logic [5:0]  pl_a  = '0;
  logic [20:0] pl_v  = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_block_mover #(.WIDTH(21), .ADDR_BITS(6)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_value(fill_value), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  // Background pattern 0x100000|addr makes untouched words recognisable.
  always @(posedge clk) begin
    if (pl_bg) begin
      for (int i = 0; i < 64; i++) mem[i] <= 21'h100000 | 21'(i);
    end else if (pl_we) begin
      mem[pl_a] <= pl_v;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic           m;
    logic [5:0]     s;
    logic [5:0]     d;
    logic [6:0]     l;
    logic [20:0]    f;
    logic           pulse;
    int             pre_n;
    logic [2:0][5:0]  pre_a;
    logic [2:0][20:0] pre_v;
    int             e_busy;
    int             e_we;
    int             e_done;
    int             e_fwe;
    logic [3:0][5:0]  ca;
    logic [3:0][20:0] cv;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload_bg();
    @(negedge clk); pl_bg = 1'b1;
    @(negedge clk); pl_bg = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [20:0] v);
    @(negedge clk); pl_we = 1'b1; pl_a = a; pl_v = v;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input logic [5:0] s, input logic [5:0] d,
                         input logic [6:0] l, input logic [20:0] f, input logic pulse,
                         output int nbusy, output int nwe, output int done_at,
                         output int first_we);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f;
    @(posedge clk);
    nbusy = 0; nwe = 0; done_at = -1; first_we = -1;
    for (int c = 0; c < 200 && done_at < 0; c++) begin
      @(negedge clk);
      start = pulse && (c == 2);
      if (busy) nbusy++;
      if (mem_we) begin
        nwe++;
        if (first_we < 0) first_we = c;
      end
      if (done) done_at = c;
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_after", {28'd0, busy, done, mem_we, |{mem_addr, mem_wdata}}, 32'd0);
  endtask

  initial begin
    int nb, nw, da, fw;
    logic saw_done;
    vt[0] = '{m:1'b0, s:6'd4, d:6'd20, l:7'd3, f:21'h0, pulse:1'b0, pre_n:3,
              pre_a:{6'd6, 6'd5, 6'd4}, pre_v:{21'h1FFFFF, 21'h2, 21'h1},
              e_busy:6, e_we:3, e_done:6, e_fwe:1,
              ca:{6'd4, 6'd22, 6'd21, 6'd20}, cv:{21'h1, 21'h1FFFFF, 21'h2, 21'h1}};
    vt[1] = '{m:1'b1, s:6'd0, d:6'd62, l:7'd4, f:21'h15555, pulse:1'b0, pre_n:0,
              pre_a:'0, pre_v:'0, e_busy:4, e_we:4, e_done:4, e_fwe:0,
              ca:{6'd1, 6'd0, 6'd63, 6'd62}, cv:{4{21'h15555}}};
    vt[2] = '{m:1'b1, s:6'd0, d:6'd30, l:7'd0, f:21'h1, pulse:1'b0, pre_n:0,
              pre_a:'0, pre_v:'0, e_busy:0, e_we:0, e_done:0, e_fwe:-1,
              ca:{6'd0, 6'd29, 6'd31, 6'd30},
              cv:{21'h100000, 21'h10001D, 21'h10001F, 21'h10001E}};
    vt[3] = '{m:1'b1, s:6'd0, d:6'd0, l:7'd100, f:21'h0ABCD, pulse:1'b0, pre_n:0,
              pre_a:'0, pre_v:'0, e_busy:64, e_we:64, e_done:64, e_fwe:0,
              ca:{6'd5, 6'd63, 6'd31, 6'd0}, cv:{4{21'h0ABCD}}};
    vt[4] = '{m:1'b0, s:6'd10, d:6'd11, l:7'd3, f:21'h0, pulse:1'b1, pre_n:1,
              pre_a:{6'd0, 6'd0, 6'd10}, pre_v:{21'h0, 21'h0, 21'h7},
              e_busy:6, e_we:3, e_done:6, e_fwe:1,
              ca:{6'd14, 6'd13, 6'd12, 6'd11}, cv:{21'h10000E, 21'h7, 21'h7, 21'h7}};
    vt[5] = '{m:1'b0, s:6'd2, d:6'd3, l:7'd0, f:21'h0, pulse:1'b0, pre_n:0,
              pre_a:'0, pre_v:'0, e_busy:0, e_we:0, e_done:0, e_fwe:-1,
              ca:{6'd5, 6'd4, 6'd2, 6'd3},
              cv:{21'h100005, 21'h100004, 21'h100002, 21'h100003}};
    vt[6] = '{m:1'b0, s:6'd62, d:6'd1, l:7'd3, f:21'h0, pulse:1'b0, pre_n:3,
              pre_a:{6'd0, 6'd63, 6'd62}, pre_v:{21'hC, 21'hB, 21'hA},
              e_busy:6, e_we:3, e_done:6, e_fwe:1,
              ca:{6'd4, 6'd3, 6'd2, 6'd1}, cv:{21'h100004, 21'hC, 21'hB, 21'hA}};

    // Reset with start held high.
    reset = 1'b1; start = 1'b1; mode = 1'b1; src_addr = 6'd1; dst_addr = 6'd2;
    len = 7'd5; fill_value = 21'h3;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
    start = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outs", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      preload_bg();
      for (int p = 0; p < vt[v].pre_n; p++) preload(vt[v].pre_a[p], vt[v].pre_v[p]);
      run_cmd(vt[v].m, vt[v].s, vt[v].d, vt[v].l, vt[v].f, vt[v].pulse, nb, nw, da, fw);
      chk($sformatf("v%0d_busy_cycles", v), nb, vt[v].e_busy);
      chk($sformatf("v%0d_we_cycles", v), nw, vt[v].e_we);
      chk($sformatf("v%0d_done_cycle", v), da, vt[v].e_done);
      chk($sformatf("v%0d_first_we", v), fw, vt[v].e_fwe);
      for (int k = 0; k < 4; k++)
        chk($sformatf("v%0d_mem[%0d]", v, vt[v].ca[k]), {11'd0, mem[vt[v].ca[k]]},
            {11'd0, vt[v].cv[k]});
    end

    // Reset during the second WRITE of a 5-word COPY.
    preload_bg();
    preload(6'd40, 21'h11);
    preload(6'd41, 21'h22);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 6'd40; dst_addr = 6'd50; len = 7'd5;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_mid_we_async", {30'd0, mem_we, busy}, 32'd0);
    @(negedge clk);
    chk("rst_mid_mem50", {11'd0, mem[50]}, 32'h11);
    chk("rst_mid_mem51", {11'd0, mem[51]}, 32'h100033);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    chk("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    run_cmd(1'b1, 6'd0, 6'd51, 7'd1, 21'h2A, 1'b0, nb, nw, da, fw);
    chk("post_rst_busy", nb, 1);
    chk("post_rst_done", da, 1);
    chk("post_rst_mem51", {11'd0, mem[51]}, 32'h2A);
    chk("post_rst_mem52", {11'd0, mem[52]}, 32'h100034);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
